// File: rtl/booth_r4_if.sv
// Request/response bundle for the radix-4 Booth multiplier.
interface booth_r4_if #(
  parameter int M = 8,
  parameter int N = 8
);
  logic             start_calc;
  logic             signed_mode;
  logic [M-1:0]     m;
  logic [N-1:0]     n;
  logic [M+N-1:0]   result;
  logic             end_sig;
  logic             busy;

  modport master (
    output start_calc, signed_mode, m, n,
    input  result, end_sig, busy
  );

  modport slave (
    input  start_calc, signed_mode, m, n,
    output result, end_sig, busy
  );
endinterface

// File: rtl/booth_r4.sv
// Radix-4 (modified Booth) sequential multiplier: two multiplier bits per
// clock, signed or unsigned operands chosen per operation.
module booth_r4 #(
  parameter int M = 8,
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       reset,
  booth_r4_if.slave  bus
);
  // Multiplier is extended to an even width so every digit has a full pair,
  // and with at least one extra bit so unsigned operands read as positive.
  localparam int NE = (N % 2 == 0) ? N + 2 : N + 1;
  localparam int K  = NE / 2;
  localparam int CW = $clog2(K);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state, state_nx;
  logic [M+1:0]     mx, a, a_nx;
  logic [NE-1:0]    q, q_nx;
  logic             q_m1;
  logic [CW-1:0]    cnt;
  logic [M+2:0]     addend, sum;
  logic [M+N-1:0]   result;
  logic             end_sig;
  logic [M+NE+1:0]  prod;
  logic             ext_m, ext_n;
  logic             accept;

  assign accept = (state == IDLE) && bus.start_calc;
  assign ext_m  = bus.signed_mode & bus.m[M-1];
  assign ext_n  = bus.signed_mode & bus.n[N-1];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: one accept in IDLE, K iterations in CALC.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start_calc) state_nx = CALC;
      CALC:    if (cnt == '0)      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Booth digit recode, add in M+3 bits, then arithmetic shift by two.
  always_comb begin
    addend = '0;
    case ({q[1:0], q_m1})
      3'b001, 3'b010: addend = {mx[M+1], mx};
      3'b011:         addend = {mx, 1'b0};
      3'b100:         addend = -{mx, 1'b0};
      3'b101, 3'b110: addend = -{mx[M+1], mx};
      default:        addend = '0;
    endcase
    sum  = {a[M+1], a} + addend;
    a_nx = {sum[M+2], sum[M+2:2]};
    q_nx = {sum[1:0], q[NE-1:2]};
  end

  // Low M+N bits are the product; the rest is sign extension only.
  assign prod = {a_nx, q_nx};
  logic unused_hi;
  assign unused_hi = ^prod[M+NE+1:M+N];

  // Datapath: operand latch on accept, iterate in CALC, publish on the last.
  always_ff @(posedge clk) begin
    if (reset) begin
      mx      <= '0;
      a       <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      end_sig <= 1'b0;
    end else begin
      end_sig <= 1'b0;
      if (accept) begin
        mx   <= {{2{ext_m}}, bus.m};
        q    <= {{(NE-N){ext_n}}, bus.n};
        q_m1 <= 1'b0;
        a    <= '0;
        cnt  <= CW'(K - 1);
      end else if (state == CALC) begin
        a    <= a_nx;
        q    <= q_nx;
        q_m1 <= q[1];
        cnt  <= cnt - 1'b1;
        if (cnt == '0) begin
          result  <= prod[M+N-1:0];
          end_sig <= 1'b1;
        end
      end
    end
  end

  assign bus.result  = result;
  assign bus.end_sig = end_sig;
  assign bus.busy    = (state == CALC);
endmodule
